rename_map: RTL



---
 rtl/rename_map.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rename_map.sv
// rename_map: multi-lane rename map table with branch checkpoints.
// For each architectural register x1..x31 it records whether the newest value
// lives in a commit station and which one. It renames up to NREN instructions
// per clock with intra-group bypass, and keeps NCKPT snapshots so that a
// mispredict restores the whole table in a single clock.
module rename_map #(
  parameter int NREN     = 4,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int RA       = LNCOMMIT + 1,
  parameter int NCKPT    = 8,
  parameter int LNCKPT   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREN-1:0]          ren_valid,
  input  logic [NREN-1:0]          ren_makes_rd,
  input  logic [5*NREN-1:0]        ren_rd,
  input  logic [LNCOMMIT*NREN-1:0] ren_tag,
  input  logic [5*NREN-1:0]        ren_rs1,
  input  logic [5*NREN-1:0]        ren_rs2,
  input  logic [NREN-1:0]          ren_ckpt,
  input  logic [LNCKPT*NREN-1:0]   ren_ckpt_id,
  input  logic                     rename_stall,
  input  logic [NCOMMIT-1:0]       commit_done,
  input  logic                     restore,
  input  logic [LNCKPT-1:0]        restore_id,
  input  logic                     flush,
  output logic [NREN-1:0]          map_valid,
  output logic [RA*NREN-1:0]       rs1_map,
  output logic [RA*NREN-1:0]       rs2_map,
  output logic [5:0]               live_count
);

  // Entry 0 exists only to keep indexing simple; it is never written valid.
  logic [31:0]         tbl_v;
  logic [31:0]         tbl_v_n;
  logic [LNCOMMIT-1:0] tbl_tag   [32];
  logic [LNCOMMIT-1:0] tbl_tag_n [32];

  logic [31:0]         ck_v     [NCKPT];
  logic [31:0]         ck_v_n   [NCKPT];
  logic [LNCOMMIT-1:0] ck_tag   [NCKPT][32];
  logic [LNCOMMIT-1:0] ck_tag_n [NCKPT][32];

  logic [NREN-1:0]    lane_wr;
  logic               accept;
  logic [RA*NREN-1:0] rs1_n;
  logic [RA*NREN-1:0] rs2_n;
  logic [5:0]         live_n;

  assign lane_wr = ren_valid & ren_makes_rd;
  assign accept  = !rename_stall && !restore && !flush;

  // Resolve one source operand: an older lane in the same group beats the
  // table, and a table entry whose station retires this clock is already
  // architectural. The last matching older lane wins, which is the youngest.
  function automatic logic [RA-1:0] map_src(input logic [4:0]          s,
                                            input int                  lane,
                                            input logic                ent_v,
                                            input logic [LNCOMMIT-1:0] ent_tag);
    logic [RA-1:0] r;
    r = RA'(s);
    if (ent_v && !commit_done[ent_tag])
      r = {1'b1, ent_tag};
    for (int j = 0; j < NREN; j++)
      if (j < lane && lane_wr[j] && ren_rd[j*5 +: 5] == s)
        r = {1'b1, ren_tag[j*LNCOMMIT +: LNCOMMIT]};
    if (s == 5'd0)
      r = '0;
    return r;
  endfunction

  // Source lookups for every lane against the pre-update table.
  always_comb begin
    rs1_n = '0;
    rs2_n = '0;
    for (int i = 0; i < NREN; i++) begin
      rs1_n[i*RA +: RA] = map_src(ren_rs1[i*5 +: 5], i,
                                  tbl_v[ren_rs1[i*5 +: 5]], tbl_tag[ren_rs1[i*5 +: 5]]);
      rs2_n[i*RA +: RA] = map_src(ren_rs2[i*5 +: 5], i,
                                  tbl_v[ren_rs2[i*5 +: 5]], tbl_tag[ren_rs2[i*5 +: 5]]);
    end
  end

  // Next table and checkpoint contents: commit clear first, then flush,
  // restore or the in-order lane updates with per-lane snapshots layered on top.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      tbl_v_n[r]   = tbl_v[r] & ~commit_done[tbl_tag[r]];
      tbl_tag_n[r] = tbl_tag[r];
    end
    for (int k = 0; k < NCKPT; k++) begin
      for (int r = 0; r < 32; r++) begin
        ck_v_n[k][r]   = ck_v[k][r] & ~commit_done[ck_tag[k][r]];
        ck_tag_n[k][r] = ck_tag[k][r];
      end
    end
    if (flush) begin
      tbl_v_n = '0;
      for (int k = 0; k < NCKPT; k++)
        ck_v_n[k] = '0;
    end else if (restore) begin
      for (int r = 0; r < 32; r++) begin
        tbl_v_n[r]   = ck_v[restore_id][r] & ~commit_done[ck_tag[restore_id][r]];
        tbl_tag_n[r] = ck_tag[restore_id][r];
      end
    end else if (!rename_stall) begin
      for (int i = 0; i < NREN; i++) begin
        if (lane_wr[i] && ren_rd[i*5 +: 5] != 5'd0) begin
          tbl_v_n[ren_rd[i*5 +: 5]]   = 1'b1;
          tbl_tag_n[ren_rd[i*5 +: 5]] = ren_tag[i*LNCOMMIT +: LNCOMMIT];
        end
        if (ren_valid[i] && ren_ckpt[i]) begin
          ck_v_n[ren_ckpt_id[i*LNCKPT +: LNCKPT]]   = tbl_v_n;
          ck_tag_n[ren_ckpt_id[i*LNCKPT +: LNCKPT]] = tbl_tag_n;
        end
      end
    end
  end

  // Population count of the next table, so live_count tracks the table itself.
  always_comb begin
    live_n = '0;
    for (int r = 1; r < 32; r++)
      live_n = live_n + {5'd0, tbl_v_n[r]};
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_v <= '0;
      for (int r = 0; r < 32; r++)
        tbl_tag[r] <= '0;
      for (int k = 0; k < NCKPT; k++) begin
        ck_v[k] <= '0;
        for (int r = 0; r < 32; r++)
          ck_tag[k][r] <= '0;
      end
      map_valid  <= '0;
      rs1_map    <= '0;
      rs2_map    <= '0;
      live_count <= '0;
    end else begin
      tbl_v <= tbl_v_n;
      for (int r = 0; r < 32; r++)
        tbl_tag[r] <= tbl_tag_n[r];
      for (int k = 0; k < NCKPT; k++) begin
        ck_v[k] <= ck_v_n[k];
        for (int r = 0; r < 32; r++)
          ck_tag[k][r] <= ck_tag_n[k][r];
      end
      map_valid  <= ren_valid & {NREN{accept}};
      rs1_map    <= rs1_n;
      rs2_map    <= rs2_n;
      live_count <= live_n;
    end
  end

endmodule
